imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Handshake and status bundle between a byte source/controller and imem_loader.
// AW must match the loader's memory address width.
interface imem_loader_if #(
  parameter int AW = 11
);
  logic          start;
  logic [63:0]   base_addr;
  logic [AW:0]   len;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic          load_error;
  logic [7:0]    csum;

  modport master (
    output start, base_addr, len, in_valid, in_byte,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, load_error, csum
  );

  modport slave (
    input  start, base_addr, len, in_valid, in_byte,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, load_error, csum
  );
endinterface

// File: rtl/imem_loader.sv
// Streams a byte source into instruction memory with range checking and status.
// Optional XOR checksum of loaded bytes enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t        state;
  logic [AW-1:0] addr_p0;
  logic [AW:0]   remaining_p0;
  logic          in_ready_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          vld_p1;
  logic [AW-1:0] wr_addr_p1;
  logic [7:0]    wr_data_p1;

  logic          accept;
  logic          start_ok;
  logic          base_oob;
  logic          range_oob;
  logic [64:0]   end_addr;

  assign accept    = bus.in_valid && in_ready_q;
  assign start_ok  = bus.start && ((state == IDLE) || (state == ERR));
  assign base_oob  = bus.base_addr > 64'(DEPTH - 1);
  assign end_addr  = {1'b0, bus.base_addr} + 65'(bus.len);
  assign range_oob = end_addr > 65'(DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vld_p1     <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= 1'b0;
      done_q <= 1'b0;
      // p0 -> p1: accepted byte becomes a registered memory write
      if (accept) begin
        vld_p1       <= 1'b1;
        wr_addr_p1   <= addr_p0;
        wr_data_p1   <= bus.in_byte;
        addr_p0      <= addr_p0 + AW'(1);
        remaining_p0 <= remaining_p0 - (AW+1)'(1);
      end
      unique case (state)
        IDLE, ERR: begin
          if (bus.start) begin
            err_q <= 1'b0;
            if (base_oob) begin
              state <= ERR;
              err_q <= 1'b1;
            end else if (bus.len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (range_oob) begin
              state <= ERR;
              err_q <= 1'b1;
            end else begin
              state        <= LOAD;
              in_ready_q   <= 1'b1;
              busy_q       <= 1'b1;
              addr_p0      <= bus.base_addr[AW-1:0];
              remaining_p0 <= bus.len;
            end
          end
        end
        LOAD: begin
          if (accept && (remaining_p0 == (AW+1)'(1))) begin
            state      <= DONE;
            done_q     <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.load_error = err_q;
  assign bus.wr_en      = vld_p1;
  assign bus.wr_addr    = wr_addr_p1;
  assign bus.wr_data    = wr_data_p1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Cleared by any start evaluated in IDLE/ERR, so a rejected load reads back 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= 8'h00;
    end else if (start_ok) begin
      csum_q <= 8'h00;
    end else if (accept) begin
      csum_q <= csum_q ^ bus.in_byte;
    end
  end

  assign bus.csum = csum_q;
`else
  assign bus.csum = 8'h00;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: bursts, gapped streams, range errors,
// zero-length loads and reset during a load.
module tb_imem_loader;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [63:0] base, input logic [AW:0] n);
    bus.base_addr = base;
    bus.len       = n;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.in_valid = 1'b1; bus.in_byte = 8'h5A;
    tick(); tick();
    got = {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
           bus.busy, bus.done, bus.load_error, bus.csum};
    n_checks++;
    if (got !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required %h", got, 32'h0);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_burst();
    logic [7:0] b [10];
    b = '{8'h30, 8'hF8, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    launch(64'd0, 12'd10);
    n_checks++;
    if ({bus.busy, bus.in_ready, bus.wr_en, bus.done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL burst_enter_load: got %b required %b",
               {bus.busy, bus.in_ready, bus.wr_en, bus.done}, 4'b1100);
    end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_byte = b[i];
      tick();
      n_checks++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, bus.busy} !==
          {1'b1, AW'(i), b[i], (i == 9), (i != 9)}) begin
        n_fail++;
        $display("FAIL burst_write[%0d]: got en=%b addr=%0d data=%h done=%b busy=%b required en=1 addr=%0d data=%h done=%b busy=%b",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, bus.busy,
                 i, b[i], (i == 9), (i != 9));
      end
    end
    n_checks++;
    if (bus.csum !== (CS ? 8'hC0 : 8'h00)) begin
      n_fail++;
      $display("FAIL burst_csum: got %h required %h", bus.csum, (CS ? 8'hC0 : 8'h00));
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if ({bus.wr_en, bus.done, bus.busy, bus.in_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL burst_idle: got %b required %b",
               {bus.wr_en, bus.done, bus.busy, bus.in_ready}, 4'b0000);
    end
  endtask

  task automatic test_gapped();
    logic       v [5];
    logic [7:0] d [5];
    int         cnt;
    v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    d = '{8'h30, 8'hEE, 8'hF7, 8'hEE, 8'h0A};
    cnt = 0;
    launch(64'd112, 12'd3);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid  = v[k];
      bus.in_byte   = d[k];
      // start during LOAD must be ignored
      bus.start     = ~v[k];
      bus.base_addr = 64'd0;
      bus.len       = 12'd1;
      tick();
      bus.start = 1'b0;
      n_checks++;
      if ({bus.wr_en, bus.done, bus.busy} !== {v[k], (k == 4), (k != 4)}) begin
        n_fail++;
        $display("FAIL gapped_ctrl[%0d]: got en/done/busy=%b required %b",
                 k, {bus.wr_en, bus.done, bus.busy}, {v[k], (k == 4), (k != 4)});
      end
      if (v[k]) begin
        n_checks++;
        if ({bus.wr_addr, bus.wr_data} !== {AW'(112 + cnt), d[k]}) begin
          n_fail++;
          $display("FAIL gapped_data[%0d]: got addr=%0d data=%h required addr=%0d data=%h",
                   k, bus.wr_addr, bus.wr_data, 112 + cnt, d[k]);
        end
        cnt++;
      end
    end
    n_checks++;
    if (bus.csum !== (CS ? 8'hCD : 8'h00)) begin
      n_fail++;
      $display("FAIL gapped_csum_done: got %h required %h", bus.csum, (CS ? 8'hCD : 8'h00));
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if ({bus.wr_en, bus.done, bus.csum} !== {2'b00, (CS ? 8'hCD : 8'h00)}) begin
      n_fail++;
      $display("FAIL gapped_hold: got en=%b done=%b csum=%h required en=0 done=0 csum=%h",
               bus.wr_en, bus.done, bus.csum, (CS ? 8'hCD : 8'h00));
    end
  endtask

  task automatic test_error();
    logic [7:0] bb;
    launch(64'd2040, 12'd9);
    n_checks++;
    if ({bus.load_error, bus.busy, bus.in_ready, bus.wr_en, bus.done, bus.csum} !== {5'b10000, 8'h00}) begin
      n_fail++;
      $display("FAIL err_enter: got err/busy/rdy/en/done=%b csum=%h required 10000 csum=00",
               {bus.load_error, bus.busy, bus.in_ready, bus.wr_en, bus.done}, bus.csum);
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.load_error, bus.wr_en, bus.busy} !== 3'b100) begin
        n_fail++;
        $display("FAIL err_hold[%0d]: got err/en/busy=%b required 100",
                 i, {bus.load_error, bus.wr_en, bus.busy});
      end
    end
    bus.in_valid = 1'b0;
    launch(64'd2048, 12'd1);
    n_checks++;
    if ({bus.load_error, bus.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_base_oob: got err/busy=%b required 10", {bus.load_error, bus.busy});
    end
    launch(64'd2046, 12'd3);
    n_checks++;
    if ({bus.load_error, bus.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_range_oob: got err/busy=%b required 10", {bus.load_error, bus.busy});
    end
    launch(64'd2045, 12'd3);
    n_checks++;
    if ({bus.load_error, bus.busy, bus.in_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL err_restart: got err/busy/rdy=%b required 011",
               {bus.load_error, bus.busy, bus.in_ready});
    end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bb = 8'hA0 + 8'(i);
      bus.in_byte = bb;
      tick();
      n_checks++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, bus.load_error} !==
          {1'b1, AW'(2045 + i), bb, (i == 2), 1'b0}) begin
        n_fail++;
        $display("FAIL top_write[%0d]: got en=%b addr=%0d data=%h done=%b err=%b required en=1 addr=%0d data=%h done=%b err=0",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, bus.load_error,
                 2045 + i, bb, (i == 2));
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_len_zero();
    launch(64'd5, 12'd0);
    n_checks++;
    if ({bus.done, bus.wr_en, bus.busy, bus.load_error} !== 4'b1000) begin
      n_fail++;
      $display("FAIL len0_done: got done/en/busy/err=%b required 1000",
               {bus.done, bus.wr_en, bus.busy, bus.load_error});
    end
    tick();
    n_checks++;
    if ({bus.done, bus.wr_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL len0_idle: got done/en=%b required 00", {bus.done, bus.wr_en});
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] got;
    logic [7:0]  bb;
    launch(64'd0, 12'd10);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_byte = 8'h40 + 8'(i);
      tick();
      n_checks++;
      if ({bus.wr_en, bus.wr_addr} !== {1'b1, AW'(i)}) begin
        n_fail++;
        $display("FAIL rst_pre_write[%0d]: got en=%b addr=%0d required en=1 addr=%0d",
                 i, bus.wr_en, bus.wr_addr, i);
      end
    end
    rst_n = 1'b0;
    bus.in_byte = 8'h99;
    tick();
    got = {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
           bus.busy, bus.done, bus.load_error, bus.csum};
    n_checks++;
    if (got !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h required %h", got, 32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({bus.wr_en, bus.busy, bus.in_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL rst_no_write[%0d]: got en/busy/rdy=%b required 000",
                 i, {bus.wr_en, bus.busy, bus.in_ready});
      end
    end
    bus.in_valid = 1'b0;
    launch(64'd20, 12'd2);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bb = 8'hC3 ^ 8'(i);
      bus.in_byte = bb;
      tick();
      n_checks++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.done} !==
          {1'b1, AW'(20 + i), bb, (i == 1)}) begin
        n_fail++;
        $display("FAIL rst_reload[%0d]: got en=%b addr=%0d data=%h done=%b required en=1 addr=%0d data=%h done=%b",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, 20 + i, bb, (i == 1));
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_burst();
    test_gapped();
    test_error();
    test_len_zero();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
